comparator_nbit_pipe: RTL and testbench

//   Parametrised, pipelined N-bit magnitude comparator; successor to the 1-bit comparator.

---
 rtl/cmp_pkg.sv | 13 +
 rtl/cmp_slice.sv | 29 ++
 rtl/comparator_nbit_pipe.sv | 132 +++++++++++++
 tb/tb_comparator_nbit_pipe.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the pipelined magnitude comparator: result encoding
// and the stage-count helper.
package cmp_pkg;

    localparam logic [1:0] CMP_EQ = 2'b00;
    localparam logic [1:0] CMP_GT = 2'b01;
    localparam logic [1:0] CMP_LT = 2'b10;

    function automatic int num_stages(input int width, input int slice_w);
        return (slice_w > 0) ? (width / slice_w) : 1;
    endfunction

endpackage

// File: rtl/cmp_slice.sv
// One slice of the magnitude compare; a decision already made upstream wins
// over the local slice compare.
module cmp_slice
    import cmp_pkg::*;
#(
    parameter int SLICE_W = 4
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               gt_in,
    input  logic               lt_in,
    output logic               gt_out,
    output logic               lt_out
);

    // pass-through priority, otherwise resolve on this slice
    always_comb begin
        gt_out = 1'b0;
        lt_out = 1'b0;
        if (gt_in || lt_in) begin
            gt_out = gt_in;
            lt_out = lt_in;
        end else begin
            gt_out = (a > b);
            lt_out = (a < b);
        end
    end

endmodule

// File: rtl/comparator_nbit_pipe.sv
// Pipelined N-bit magnitude comparator, MSB slice first, one slice per stage,
// valid/ready on both sides with a single global advance.
module comparator_nbit_pipe
    import cmp_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SLICE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a_gt_b,
    output logic             a_lt_b,
    output logic             a_eq_b
);

    localparam int NUM_STAGES = num_stages(WIDTH, SLICE_W);

    if ((SLICE_W < 1) ? 1'b1 : ((WIDTH % SLICE_W) != 0)) begin : g_bad_params
        $error("comparator_nbit_pipe: WIDTH must be a positive multiple of SLICE_W");
    end

    logic             w_adv;
    logic [WIDTH-1:0] w_a_ob;
    logic [WIDTH-1:0] w_b_ob;
    logic             w_last_v;
    logic             w_last_gt;
    logic             w_last_lt;
    logic [1:0]       w_res;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    // Offset-binary: flipping the sign bit makes signed order match unsigned order.
    assign w_a_ob = in_a ^ (WIDTH'(in_signed) << (WIDTH - 1));
    assign w_b_ob = in_b ^ (WIDTH'(in_signed) << (WIDTH - 1));

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        localparam int IN_W  = WIDTH - k * SLICE_W;
        localparam int REM_W = IN_W - SLICE_W;

        logic [IN_W-1:0] w_a_in;
        logic [IN_W-1:0] w_b_in;
        logic            w_v_in;
        logic            w_gt_in;
        logic            w_lt_in;
        logic            w_gt;
        logic            w_lt;
        logic            r_v;
        logic            r_gt;
        logic            r_lt;

        if (k == 0) begin : g_head
            assign w_a_in  = w_a_ob;
            assign w_b_in  = w_b_ob;
            assign w_v_in  = in_valid;
            assign w_gt_in = 1'b0;
            assign w_lt_in = 1'b0;
        end else begin : g_body
            assign w_a_in  = g_stage[k-1].g_op.r_a;
            assign w_b_in  = g_stage[k-1].g_op.r_b;
            assign w_v_in  = g_stage[k-1].r_v;
            assign w_gt_in = g_stage[k-1].r_gt;
            assign w_lt_in = g_stage[k-1].r_lt;
        end

        cmp_slice #(.SLICE_W(SLICE_W)) u_slice (
            .a      (w_a_in[IN_W-1 -: SLICE_W]),
            .b      (w_b_in[IN_W-1 -: SLICE_W]),
            .gt_in  (w_gt_in),
            .lt_in  (w_lt_in),
            .gt_out (w_gt),
            .lt_out (w_lt)
        );

        // stage valid and decision register
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_v  <= 1'b0;
                r_gt <= 1'b0;
                r_lt <= 1'b0;
            end else if (w_adv) begin
                r_v  <= w_v_in;
                r_gt <= w_gt;
                r_lt <= w_lt;
            end
        end

        // Only the not-yet-compared lower bits travel on to the next stage.
        if (REM_W > 0) begin : g_op
            logic [REM_W-1:0] r_a;
            logic [REM_W-1:0] r_b;

            // remaining operand bits
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_a_in[REM_W-1:0];
                    r_b <= w_b_in[REM_W-1:0];
                end
            end
        end
    end

    assign w_last_v  = g_stage[NUM_STAGES-1].r_v;
    assign w_last_gt = g_stage[NUM_STAGES-1].r_gt;
    assign w_last_lt = g_stage[NUM_STAGES-1].r_lt;
    assign out_valid = w_last_v;

    // encode final decision
    always_comb begin
        w_res = CMP_EQ;
        case ({w_last_lt, w_last_gt})
            2'b01:   w_res = CMP_GT;
            2'b10:   w_res = CMP_LT;
            default: w_res = CMP_EQ;
        endcase
    end

    assign a_gt_b = w_last_v && (w_res == CMP_GT);
    assign a_lt_b = w_last_v && (w_res == CMP_LT);
    assign a_eq_b = w_last_v && (w_res == CMP_EQ);

endmodule

// File: tb/tb_comparator_nbit_pipe.sv
// Self-checking bench for comparator_nbit_pipe (WIDTH=16, SLICE_W=4) using a
// vector table, a result scoreboard queue and hand-written corner sequences.
module tb_comparator_nbit_pipe;

    localparam int W  = 16;
    localparam int SW = 4;
    localparam int NS = 4;

    localparam logic [2:0] E_GT = 3'b100;
    localparam logic [2:0] E_LT = 3'b010;
    localparam logic [2:0] E_EQ = 3'b001;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_signed;
    logic         out_valid;
    logic         out_ready;
    logic         a_gt_b;
    logic         a_lt_b;
    logic         a_eq_b;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [2:0]  e;
    } vec_t;

    vec_t       tbl [10];
    logic [2:0] exp_q [$];
    int         n_tests  = 0;
    int         n_fail   = 0;
    int         xfer_cnt = 0;
    bit         seen_out = 1'b0;

    comparator_nbit_pipe #(.WIDTH(W), .SLICE_W(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_gt_b    (a_gt_b),
        .a_lt_b    (a_lt_b),
        .a_eq_b    (a_eq_b)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
        if (s) begin
            if ($signed(a) > $signed(b)) return E_GT;
            else if ($signed(a) < $signed(b)) return E_LT;
            else return E_EQ;
        end else begin
            if (a > b) return E_GT;
            else if (a < b) return E_LT;
            else return E_EQ;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic ordy, input logic [2:0] e);
        @(negedge clk);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_signed = s;
        out_ready = ordy;
        #1;
        seen_out = 1'b0;
        check("in_ready", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
        if (out_valid && out_ready) begin
            seen_out = 1'b1;
            xfer_cnt++;
            if (exp_q.size() == 0) check("spurious_out", 32'd1, 32'd0);
            else check("result", {29'd0, a_gt_b, a_lt_b, a_eq_b}, {29'd0, exp_q.pop_front()});
        end else if (!out_valid) begin
            check("flags_idle", {29'd0, a_gt_b, a_lt_b, a_eq_b}, 32'd0);
        end
        if (in_valid && in_ready) exp_q.push_back(e);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 16'($urandom()), 16'($urandom()), 1'b0, ordy, 3'b000);
    endtask

    task automatic measure_latency(output int lat);
        lat = 0;
        do begin
            idle(1'b1);
            lat++;
        end while (!seen_out && lat < 20);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rs;
        logic [2:0]  cap;
        int          lat;
        int          x0;

        tbl[0] = '{16'h1234, 16'h1234, 1'b0, E_EQ};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b1, E_LT};
        tbl[2] = '{16'hFFFF, 16'h0001, 1'b0, E_GT};
        tbl[3] = '{16'h00A1, 16'h00A0, 1'b0, E_GT};
        tbl[4] = '{16'h1000, 16'h0FFF, 1'b0, E_GT};
        tbl[5] = '{16'h0FFF, 16'h1000, 1'b0, E_LT};
        tbl[6] = '{16'h8000, 16'h7FFF, 1'b1, E_LT};
        tbl[7] = '{16'h8000, 16'h7FFF, 1'b0, E_GT};
        tbl[8] = '{16'h0000, 16'h0000, 1'b1, E_EQ};
        tbl[9] = '{16'h7FFF, 16'h8000, 1'b1, E_GT};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 16'h0000;
        in_b      = 16'h0000;
        in_signed = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_flags", {29'd0, a_gt_b, a_lt_b, a_eq_b}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // single pair: latency through all stages
        step(1'b1, 16'h1234, 16'h1234, 1'b0, 1'b1, E_EQ);
        measure_latency(lat);
        check("latency", lat, NS);

        // table vectors back to back, then drain
        for (int i = 0; i < 10; i++) begin
            step(1'b1, tbl[i].a, tbl[i].b, tbl[i].s, 1'b1, tbl[i].e);
        end
        repeat (NS + 2) idle(1'b1);
        check("table_drained", exp_q.size(), 32'd0);

        // 8-pair stream: all 8 results must appear on consecutive cycles
        x0 = xfer_cnt;
        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom());
            rb = (i == 3) ? ra : 16'($urandom());
            rs = 1'($urandom());
            step(1'b1, ra, rb, rs, 1'b1, model(ra, rb, rs));
        end
        repeat (NS) idle(1'b1);
        check("stream_count", xfer_cnt - x0, 32'd8);
        check("stream_q_empty", exp_q.size(), 32'd0);

        // backpressure: fill, stall 5 cycles with changing inputs, then drain
        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom());
            rb = 16'($urandom());
            rs = 1'($urandom());
            step(1'b1, ra, rb, rs, 1'b1, model(ra, rb, rs));
        end
        cap = 3'b000;
        for (int i = 0; i < 5; i++) begin
            ra = 16'($urandom());
            rb = 16'($urandom());
            rs = 1'($urandom());
            step(1'b1, ra, rb, rs, 1'b0, model(ra, rb, rs));
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            if (i == 0) cap = {a_gt_b, a_lt_b, a_eq_b};
            else check("bp_flags_stable", {29'd0, a_gt_b, a_lt_b, a_eq_b}, {29'd0, cap});
        end
        repeat (10) idle(1'b1);
        check("bp_q_empty", exp_q.size(), 32'd0);

        // reset with 3 pairs in flight, the oldest stalled at the output
        step(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b1, E_LT);
        step(1'b1, 16'h0003, 16'h0002, 1'b0, 1'b1, E_GT);
        step(1'b1, 16'h0004, 16'h0004, 1'b0, 1'b1, E_EQ);
        idle(1'b0);
        idle(1'b0);
        check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_flags", {29'd0, a_gt_b, a_lt_b, a_eq_b}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        x0 = xfer_cnt;
        step(1'b1, 16'h00A1, 16'h00A0, 1'b0, 1'b1, E_GT);
        measure_latency(lat);
        check("post_reset_latency", lat, NS);
        repeat (6) idle(1'b1);
        check("post_reset_single", xfer_cnt - x0, 32'd1);
        check("post_reset_q_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
